// File: rtl/skip_branch_ctrl_if.sv
// ============================================================================
//  Module      : skip_branch_ctrl_if
//  Description : Bundle between the execute stage and the skip/branch
//                controller. It carries the instruction and operand buses
//                into the controller, and the PC/stack/flush controls out
//                of it.
//                master : core side. It drives the instruction and operand
//                         buses.
//                slave  : controller side. It drives the PC, stack and
//                         flush controls.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface skip_branch_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic [11:0]      instr;
  logic [7:0]       status_bus;
  logic [7:0]       file_bus;
  logic [7:0]       alu_result;
  logic [PC_W-1:0]  stack_top;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic             stack_push;
  logic             stack_pop;
  logic             flush;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_valid, instr, status_bus, file_bus, alu_result, stack_top,
    input  pc_load, pc_target, stack_push, stack_pop, flush, flush_cnt
  );

  modport slave (
    input  instr_valid, instr, status_bus, file_bus, alu_result, stack_top,
    output pc_load, pc_target, stack_push, stack_pop, flush, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/skip_branch_ctrl.sv
// ============================================================================
//  Module      : skip_branch_ctrl
//  Description : Decodes the executing PIC10F200 instruction. It evaluates
//                the BTFSC/BTFSS/DECFSZ/INCFSZ skip conditions and issues
//                the GOTO/CALL/RETLW program-flow controls. A one-cycle
//                pipeline flush follows every taken skip or branch.
//  Ports       : clk      - system clock; all state changes on the rising
//                           edge
//                rst      - synchronous reset, active low
//                bus      - skip_branch_ctrl_if.slave. Carries:
//                           - inputs : instr_valid, instr, status_bus,
//                                      file_bus, alu_result, stack_top
//                           - outputs: pc_load, pc_target, stack_push,
//                                      stack_pop, flush, flush_cnt
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module skip_branch_ctrl #(
  parameter int         PC_W     = 9,
  parameter int         CNT_W    = 8,
  parameter logic [4:0] STATUS_A = 5'h03
) (
  input  wire logic           clk,
  input  wire logic           rst,
  skip_branch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_flush;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_decode;
  logic [7:0]       w_src;
  logic             w_src_bit;
  logic             w_skip;
  logic             w_take;
  logic             w_pc_load;
  logic             w_stack_push;
  logic             w_stack_pop;
  logic [PC_W-1:0]  w_pc_target;

  // Decode is only meaningful on a live instruction in RUN. IDLE and FLUSH
  // cycles carry a discarded instruction.
  assign w_decode  = (r_state == ST_RUN) && bus.instr_valid;

  // A bit test on the STATUS address reads the live STATUS bus. This avoids
  // depending on the file-read mux, which does not alias STATUS.
  assign w_src     = (bus.instr[4:0] == STATUS_A) ? bus.status_bus : bus.file_bus;
  assign w_src_bit = w_src[bus.instr[7:5]];

  always_comb begin
    w_skip       = 1'b0;
    w_pc_load    = 1'b0;
    w_stack_push = 1'b0;
    w_stack_pop  = 1'b0;
    w_pc_target  = '0;
    if (w_decode) begin
      if (bus.instr[11:8] == 4'b0110) begin            // BTFSC
        w_skip = ~w_src_bit;
      end else if (bus.instr[11:8] == 4'b0111) begin   // BTFSS
        w_skip = w_src_bit;
      end else if ((bus.instr[11:6] == 6'b001011) ||   // DECFSZ
                   (bus.instr[11:6] == 6'b001111)) begin // INCFSZ
        w_skip = (bus.alu_result == 8'h00);
      end else if (bus.instr[11:9] == 3'b101) begin    // GOTO
        w_pc_load   = 1'b1;
        w_pc_target = PC_W'(bus.instr[8:0]);
      end else if (bus.instr[11:8] == 4'b1001) begin   // CALL: page bit 8 is forced low
        w_pc_load    = 1'b1;
        w_stack_push = 1'b1;
        w_pc_target  = PC_W'({1'b0, bus.instr[7:0]});
      end else if (bus.instr[11:8] == 4'b1000) begin   // RETLW
        w_pc_load   = 1'b1;
        w_stack_pop = 1'b1;
        w_pc_target = bus.stack_top;
      end
    end
  end

  assign w_take = w_skip | w_pc_load;

  // flush is kept as its own register. It is updated together with the
  // state, so it always equals (state != RUN) without a decode after the
  // flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_flush     <= 1'b1;
      r_flush_cnt <= '0;
    end else begin
      if (r_flush) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
        ST_RUN: begin
          if (w_take) begin
            r_state <= ST_FLUSH;
            r_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_load    = w_pc_load;
  assign bus.pc_target  = w_pc_target;
  assign bus.stack_push = w_stack_push;
  assign bus.stack_pop  = w_stack_pop;
  assign bus.flush      = r_flush;
  assign bus.flush_cnt  = r_flush_cnt;

endmodule

`default_nettype wire
